logic_gate_unit: RTL and testbench

- Parametrised successor to the two-input AND gate.
- Applies one of eight selectable bitwise two-operand operations to WIDTH-bit operands a and b.
- Result is registered behind a valid/ready handshake with a one-entry skid buffer, so upstream and downstream can stall independently without losing data.
- Also provides registered reduction flags and a saturating count of delivered results. Used as the standard gate primitive for streaming datapaths.

---
 rtl/logic_gate_unit.sv | 129 ++++++++++++
 tb/tb_logic_gate_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// logic_gate_unit
//   Streaming bitwise two-operand gate. One of eight ops is applied to
//   a/b, the result is registered behind a valid/ready handshake with a
//   one-entry skid buffer, and registered reduction flags plus a
//   saturating delivered-result counter are provided.
// Ports
//   clk, rst_n          clock, async active-low reset
//   a, b, op            operands and op select (sampled on accept)
//   in_valid, in_ready  upstream handshake (in_ready = skid empty)
//   y, y_all, y_any     registered result and its &/| reductions
//   out_valid, out_ready downstream handshake
//   count_clr           synchronous clear of result_count
//   result_count        saturating count of output handshakes

// One result bit. The op decode is shared; each lane sees its own a/b bit.
module logic_gate_lane (
  input  logic [2:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_y
);
  always_comb begin
    o_y = 1'b0;
    case (i_op)
      3'b000: o_y =   i_a & i_b;
      3'b001: o_y =   i_a | i_b;
      3'b010: o_y =   i_a ^ i_b;
      3'b011: o_y = ~(i_a & i_b);
      3'b100: o_y = ~(i_a | i_b);
      3'b101: o_y = ~(i_a ^ i_b);
      3'b110: o_y =  ~i_a;
      default: o_y =  i_a;
    endcase
  end
endmodule

module logic_gate_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y,
  output logic               y_all,
  output logic               y_any,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               count_clr,
  output logic [COUNT_W-1:0] result_count
);

  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_load_y;
  logic               w_acc;
  logic               w_drain;
  logic               w_main_free;

  logic               r_main_vld;
  logic [WIDTH-1:0]   r_main_y;
  logic               r_main_all;
  logic               r_main_any;
  logic               r_skid_vld;
  logic [WIDTH-1:0]   r_skid_y;
  logic [COUNT_W-1:0] r_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic_gate_lane u_lane (
      .i_op (op),
      .i_a  (a[i]),
      .i_b  (b[i]),
      .o_y  (w_res[i])
    );
  end

  // in_ready is purely the registered skid state, so upstream never sees a
  // combinational path from out_ready.
  assign in_ready    = !r_skid_vld;
  assign w_acc       = in_valid && !r_skid_vld;
  assign w_drain     = r_main_vld && out_ready;
  assign w_main_free = !r_main_vld || w_drain;
  // A full skid always has priority for the main slot; it blocks accepts.
  assign w_load_y    = r_skid_vld ? r_skid_y : w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld <= 1'b0;
      r_main_y   <= '0;
      r_main_all <= 1'b0;
      r_main_any <= 1'b0;
      r_skid_vld <= 1'b0;
      r_skid_y   <= '0;
    end else if (w_main_free) begin
      if (r_skid_vld || w_acc) begin
        r_main_vld <= 1'b1;
        r_main_y   <= w_load_y;
        // Flags come from the value being loaded so they always match y.
        r_main_all <= &w_load_y;
        r_main_any <= |w_load_y;
      end else begin
        r_main_vld <= 1'b0;
      end
      r_skid_vld <= 1'b0;
    end else if (w_acc) begin
      r_skid_vld <= 1'b1;
      r_skid_y   <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (count_clr)
      r_cnt <= '0;
    else if (w_drain && (r_cnt != {COUNT_W{1'b1}}))
      r_cnt <= r_cnt + COUNT_W'(1);
  end

  assign y            = r_main_y;
  assign y_all        = r_main_all;
  assign y_any        = r_main_any;
  assign out_valid    = r_main_vld;
  assign result_count = r_cnt;

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       in_valid, out_ready, count_clr;

  logic        rdy8, all8, any8, ov8;
  logic [7:0]  y8;
  logic [15:0] cnt8;
  logic        rdyc, allc, anyc, ovc;
  logic [7:0]  yc;
  logic [1:0]  cntc;
  logic        rdy1, all1, any1, ov1;
  logic [0:0]  y1;
  logic [15:0] cnt1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .COUNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(rdy8), .y(y8), .y_all(all8), .y_any(any8),
    .out_valid(ov8), .out_ready(out_ready), .count_clr(count_clr),
    .result_count(cnt8));

  logic_gate_unit #(.WIDTH(8), .COUNT_W(2)) dutc (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(rdyc), .y(yc), .y_all(allc), .y_any(anyc),
    .out_valid(ovc), .out_ready(out_ready), .count_clr(count_clr),
    .result_count(cntc));

  logic_gate_unit #(.WIDTH(1), .COUNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .op(op),
    .in_valid(in_valid), .in_ready(rdy1), .y(y1), .y_all(all1), .y_any(any1),
    .out_valid(ov1), .out_ready(out_ready), .count_clr(count_clr),
    .result_count(cnt1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: each op is a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [3:0] tt;
    logic [7:0] r;
    case (o)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  // Scoreboard: a FIFO of accepted results. Occupancy alone predicts the
  // handshake signals: valid when non-empty, ready while fewer than two held.
  logic [7:0] q[$];
  int mcnt8 = 0;
  int mcntc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt8 = 0;
      mcntc = 0;
    end else begin
      logic       e_ov, e_rdy, hs;
      logic [7:0] e;
      e_ov  = (q.size() > 0);
      e_rdy = (q.size() < 2);
      chk("out_valid", 32'({ov8, ovc, ov1}), 32'({3{e_ov}}));
      chk("in_ready", 32'({rdy8, rdyc, rdy1}), 32'({3{e_rdy}}));
      chk("count16", 32'(cnt8), 32'(mcnt8));
      chk("count2", 32'(cntc), 32'(mcntc));
      chk("count_w1", 32'(cnt1), 32'(mcnt8));
      hs = e_ov && out_ready;
      if (hs) begin
        e = q.pop_front();
        chk("y", 32'(y8), 32'(e));
        chk("y_flags", 32'({all8, any8}), 32'({&e, |e}));
        chk("y_cnt2", 32'({yc, allc, anyc}), 32'({e, &e, |e}));
        chk("y_w1", 32'({y1, all1, any1}), 32'({3{e[0]}}));
      end
      if (count_clr) begin
        mcnt8 = 0;
        mcntc = 0;
      end else if (hs) begin
        mcnt8 = (mcnt8 < 65535) ? mcnt8 + 1 : 65535;
        mcntc = (mcntc < 3) ? mcntc + 1 : 3;
      end
      if (in_valid && e_rdy) q.push_back(ref_op(op, a, b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, y;
    logic       all, any;
  } vec_t;

  // Called at posedge+1 with the pipeline empty: accept, check, deliver.
  task automatic apply_one(input vec_t v);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("tbl_valid", 32'(ov8), 32'(1));
    chk("tbl_y", 32'(y8), 32'(v.y));
    chk("tbl_flags", 32'({all8, any8}), 32'({v.all, v.any}));
    chk("tbl_w1", 32'({y1, all1, any1}), 32'({3{v.y[0]}}));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    int   cexp[5];
    tbl[0]  = '{3'd0, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b1};
    tbl[1]  = '{3'd1, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b1};
    tbl[2]  = '{3'd2, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b1};
    tbl[3]  = '{3'd3, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b1};
    tbl[4]  = '{3'd4, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b1};
    tbl[5]  = '{3'd5, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b1};
    tbl[6]  = '{3'd6, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b1};
    tbl[7]  = '{3'd7, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b1};
    tbl[8]  = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1};
    tbl[9]  = '{3'd0, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{3'd0, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{3'd0, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{3'd0, 8'h01, 8'h01, 8'h01, 1'b0, 1'b1};
    cexp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0; a = '0; b = '0; op = '0;
    in_valid = 1'b0; out_ready = 1'b0; count_clr = 1'b0;
    #2;
    chk("rst_y", 32'({y8, yc, y1}), 32'(0));
    chk("rst_flags", 32'({all8, any8, all1, any1}), 32'(0));
    chk("rst_valid", 32'({ov8, ovc, ov1}), 32'(0));
    chk("rst_ready", 32'({rdy8, rdyc, rdy1}), 32'(3'b111));
    chk("rst_count", 32'({cnt8, cntc}), 32'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) apply_one(tbl[i]);

    // Backpressure: R1 to main, R2 to skid, R3 held until drain begins.
    out_ready = 1'b0; op = 3'd7; a = 8'h11; in_valid = 1'b1;
    step();
    a = 8'h22;
    @(negedge clk);
    chk("bp_r1_y", 32'(y8), 32'(8'h11));
    chk("bp_r1_rdy", 32'(rdy8), 32'(1));
    step();
    a = 8'h33;
    @(negedge clk);
    chk("bp_r2_skid_rdy", 32'(rdy8), 32'(0));
    chk("bp_hold_y", 32'(y8), 32'(8'h11));
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_stall_y", 32'(y8), 32'(8'h11));
    chk("bp_stall_rdy", 32'(rdy8), 32'(0));
    step();
    @(negedge clk);
    chk("bp_r2_main_y", 32'(y8), 32'(8'h22));
    chk("bp_rdy_back", 32'(rdy8), 32'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_r3_y", 32'(y8), 32'(8'h33));
    step();
    @(negedge clk);
    chk("bp_empty", 32'(ov8), 32'(0));
    step();

    // Asynchronous reset in the middle of a stalled burst.
    out_ready = 1'b0; op = 3'd7; a = 8'h77; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full", 32'({ov8, rdy8}), 32'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'({ov8, ovc, ov1}), 32'(0));
    chk("mid_rst_ready", 32'({rdy8, rdyc, rdy1}), 32'(3'b111));
    chk("mid_rst_y", 32'(y8), 32'(0));
    chk("mid_rst_count", 32'({cnt8, cntc}), 32'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    step();

    // Saturating 2-bit counter, then clear beating a simultaneous handshake.
    for (int i = 0; i < 5; i++) begin
      apply_one(tbl[i]);
      @(negedge clk);
      chk("cnt2_sat", 32'(cntc), 32'(cexp[i]));
      chk("cnt16_inc", 32'(cnt8), 32'(i + 1));
      step();
    end
    op = 3'd1; a = 8'h01; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; count_clr = 1'b1;
    step();
    count_clr = 1'b0;
    @(negedge clk);
    chk("clr_prio", 32'({cnt8, cntc}), 32'(0));
    chk("clr_drained", 32'(ov8), 32'(0));
    step();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op        = 3'($urandom);
      a         = 8'($urandom);
      b         = 8'($urandom);
      count_clr = ($urandom_range(0, 40) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("final_empty", 32'(ov8), 32'(0));
    chk("final_queue", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
